// File: rtl/fuzzy_rule_engine.sv
// fuzzy_rule_engine: 3x3 Mamdani rule inference with singleton defuzzification via restoring divider
module fuzzy_rule_engine (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [15:0]        mu_e_neg,
    input  logic [15:0]        mu_e_zero,
    input  logic [15:0]        mu_e_pos,
    input  logic [15:0]        mu_de_neg,
    input  logic [15:0]        mu_de_zero,
    input  logic [15:0]        mu_de_pos,
    input  logic [71:0]        rule_s,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [7:0]  y,
    output logic               den_zero
);
    typedef enum logic [1:0] {IDLE, RULE, DIV, DONE} state_t;
    state_t              r_state;
    state_t              w_next;
    logic [15:0]         r_mu_e [3];
    logic [15:0]         r_mu_de [3];
    logic signed [7:0]   r_s [9];
    logic [3:0]          r_k;
    logic [4:0]          r_cnt;
    logic signed [28:0]  r_num;
    logic [19:0]         r_den;
    logic [27:0]         r_quo;
    logic [19:0]         r_rem;
    logic                r_neg;
    logic signed [7:0]   r_y;
    logic                r_den_zero;
    logic [1:0]          w_i;
    logic [1:0]          w_j;
    logic [15:0]         w_w;
    logic signed [7:0]   w_s;
    logic signed [24:0]  w_wx;
    logic signed [24:0]  w_sx;
    logic signed [24:0]  w_prod;
    logic signed [28:0]  w_num_nx;
    logic [19:0]         w_den_nx;
    logic [20:0]         w_rem_sh;
    logic                w_ge;
    logic [19:0]         w_rem_nx;
    logic [27:0]         w_quo_nx;
    logic [7:0]          w_q;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign y         = r_y;
    assign den_zero  = r_den_zero;

    // rule weight/product for the current k, plus one restoring-divider step
    always_comb begin
        w_i      = (r_k >= 4'd6) ? 2'd2 : (r_k >= 4'd3) ? 2'd1 : 2'd0;
        w_j      = 2'(r_k - ((r_k >= 4'd6) ? 4'd6 : (r_k >= 4'd3) ? 4'd3 : 4'd0));
        w_w      = (r_mu_e[w_i] < r_mu_de[w_j]) ? r_mu_e[w_i] : r_mu_de[w_j];
        w_s      = r_s[r_k];
        w_wx     = {9'b0, w_w};
        w_sx     = {{17{w_s[7]}}, w_s};
        w_prod   = w_wx * w_sx;
        w_num_nx = r_num + {{4{w_prod[24]}}, w_prod};
        w_den_nx = r_den + {4'b0, w_w};
        w_rem_sh = {r_rem, r_quo[27]};
        w_ge     = (w_rem_sh >= {1'b0, r_den});
        w_rem_nx = w_ge ? (w_rem_sh[19:0] - r_den) : w_rem_sh[19:0];
        w_quo_nx = {r_quo[26:0], w_ge};
        w_q      = r_neg ? (8'd0 - w_quo_nx[7:0]) : w_quo_nx[7:0];
    end

    // next-state decode: IDLE->RULE->DIV->DONE->IDLE
    always_comb begin
        w_next = r_state;
        if (r_state == IDLE && in_valid)
            w_next = RULE;
        else if (r_state == RULE && r_k == 4'd8)
            w_next = DIV;
        else if (r_state == DIV && r_cnt == 5'd27)
            w_next = DONE;
        else if (r_state == DONE && out_ready)
            w_next = IDLE;
    end

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // capture, accumulate, divide; the divider is loaded on the last rule cycle with the final sums
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int n = 0; n < 3; n++) begin
                r_mu_e[n]  <= '0;
                r_mu_de[n] <= '0;
            end
            for (int n = 0; n < 9; n++)
                r_s[n] <= '0;
            r_k        <= '0;
            r_cnt      <= '0;
            r_num      <= '0;
            r_den      <= '0;
            r_quo      <= '0;
            r_rem      <= '0;
            r_neg      <= 1'b0;
            r_y        <= '0;
            r_den_zero <= 1'b0;
        end else if (r_state == IDLE) begin
            if (in_valid) begin
                r_mu_e[0]  <= mu_e_neg;
                r_mu_e[1]  <= mu_e_zero;
                r_mu_e[2]  <= mu_e_pos;
                r_mu_de[0] <= mu_de_neg;
                r_mu_de[1] <= mu_de_zero;
                r_mu_de[2] <= mu_de_pos;
                for (int n = 0; n < 9; n++)
                    r_s[n] <= rule_s[8*n +: 8];
                r_k   <= '0;
                r_num <= '0;
                r_den <= '0;
            end
        end else if (r_state == RULE) begin
            r_num <= w_num_nx;
            r_den <= w_den_nx;
            r_k   <= r_k + 4'd1;
            if (r_k == 4'd8) begin
                r_quo <= w_num_nx[28] ? 28'(-w_num_nx) : 28'(w_num_nx);
                r_rem <= '0;
                r_neg <= w_num_nx[28];
                r_cnt <= '0;
            end
        end else if (r_state == DIV) begin
            r_quo <= w_quo_nx;
            r_rem <= w_rem_nx;
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'd27) begin
                r_y        <= (r_den == '0) ? 8'sd0 : $signed(w_q);
                r_den_zero <= (r_den == '0);
            end
        end
    end
endmodule

// File: tb/tb_fuzzy_rule_engine.sv
// tb_fuzzy_rule_engine: directed vectors with a queue scoreboard and an independent output monitor
module tb_fuzzy_rule_engine;
    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       mu_e_neg, mu_e_zero, mu_e_pos;
    logic [15:0]       mu_de_neg, mu_de_zero, mu_de_pos;
    logic [71:0]       rule_s;
    logic              out_valid;
    logic              out_ready;
    logic signed [7:0] y;
    logic              den_zero;

    typedef struct {int y; int dz; int t;} exp_t;
    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   t_acc;

    fuzzy_rule_engine dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .mu_e_neg(mu_e_neg), .mu_e_zero(mu_e_zero), .mu_e_pos(mu_e_pos),
        .mu_de_neg(mu_de_neg), .mu_de_zero(mu_de_zero), .mu_de_pos(mu_de_pos),
        .rule_s(rule_s), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .den_zero(den_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    function automatic logic [71:0] mk_s(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
        return {8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    endfunction

    task automatic scramble();
        mu_e_neg  = 16'($urandom); mu_e_zero  = 16'($urandom); mu_e_pos  = 16'($urandom);
        mu_de_neg = 16'($urandom); mu_de_zero = 16'($urandom); mu_de_pos = 16'($urandom);
        rule_s    = 72'({$urandom, $urandom, $urandom});
    endtask

    task automatic set_in(input logic [15:0] e0, e1, e2, d0, d1, d2, input logic [71:0] s);
        mu_e_neg = e0; mu_e_zero = e1; mu_e_pos = e2;
        mu_de_neg = d0; mu_de_zero = d1; mu_de_pos = d2;
        rule_s = s;
    endtask

    task automatic send(input logic [15:0] e0, e1, e2, d0, d1, d2, input logic [71:0] s,
                        input int ey, input int edz, input bit push, output int ta);
        int n;
        exp_t e;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        ta = 0;
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_wait: in_ready=%0d after %0d cycles, required 1", in_ready, n);
        end else begin
            set_in(e0, e1, e2, d0, d1, d2, s);
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            ta = cyc;
            if (push) begin
                e.y = ey; e.dz = edz; e.t = cyc;
                q.push_back(e);
            end
            in_valid = 1'b0;
            scramble();
        end
    endtask

    // monitor: pops the scoreboard on each rising out_valid and checks stability while held
    initial begin
        bit   prev_ov = 1'b0;
        int   held_y = 0;
        int   held_dz = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && !prev_ov) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_out: y=%0d den_zero=%0d with no pending transaction", y, den_zero);
                end else begin
                    e = q.pop_front();
                    chk("y", int'(y), e.y);
                    chk("den_zero", int'(den_zero), e.dz);
                    chk("latency", cyc - e.t, 37);
                end
                held_y  = int'(y);
                held_dz = int'(den_zero);
            end else if (rst_n && out_valid) begin
                chk("hold_y", int'(y), held_y);
                chk("hold_den_zero", int'(den_zero), held_dz);
                chk("hold_in_ready", int'(in_ready), 0);
            end
            prev_ov = out_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int n;
        exp_t e;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, '0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_y", int'(y), 0);
        chk("rst_den_zero", int'(den_zero), 0);

        send(16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000,
             mk_s(0, 0, 0, 0, 40, 0, 0, 0, 0), 40, 0, 1, t_acc);
        send(16'hFFFF, 16'h0000, 16'h0000, 16'h8000, 16'h8000, 16'h0000,
             mk_s(100, -20, 0, 0, 0, 0, 0, 0, 0), 40, 0, 1, t_acc);
        send(16'hFFFF, 16'h0000, 16'h0000, 16'h0001, 16'h0001, 16'h0000,
             mk_s(-7, 0, 0, 0, 0, 0, 0, 0, 0), -3, 0, 1, t_acc);
        send(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
             mk_s(5, 5, 5, 5, 5, 5, 5, 5, 5), 0, 1, 1, t_acc);
        send(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
             mk_s(127, 127, 127, 127, 127, 127, 127, 127, 127), 127, 0, 1, t_acc);
        send(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
             mk_s(-128, -128, -128, -128, -128, -128, -128, -128, -128), -128, 0, 1, t_acc);
        send(16'h1000, 16'h3000, 16'h0000, 16'h0000, 16'h2000, 16'h2000,
             mk_s(99, 10, 20, -99, -30, 50, 77, 77, 77), 11, 0, 1, t_acc);
        send(16'h0000, 16'h0000, 16'h0003, 16'h0000, 16'h0001, 16'h0003,
             mk_s(0, 0, 0, 0, 0, 0, 100, -10, -1), -3, 0, 1, t_acc);

        // back-pressure: hold the result, wiggle inputs, then release with in_valid already high
        send(16'hFFFF, 16'h0000, 16'h0000, 16'h8000, 16'h8000, 16'h0000,
             mk_s(100, -20, 0, 0, 0, 0, 0, 0, 0), 40, 0, 1, t_acc);
        out_ready = 1'b0;
        n = 0;
        while (!out_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("bp_out_valid_rise", int'(out_valid), 1);
        repeat (10) begin
            @(negedge clk);
            in_valid = ~in_valid;
            scramble();
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_out_valid", int'(out_valid), 1);
        end
        @(negedge clk);
        set_in(16'h1000, 16'h3000, 16'h0000, 16'h0000, 16'h2000, 16'h2000,
               mk_s(99, 10, 20, -99, -30, 50, 77, 77, 77));
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release_in_ready", int'(in_ready), 1);
        chk("release_out_valid", int'(out_valid), 0);
        @(posedge clk);
        #1;
        e.y = 11; e.dz = 0; e.t = cyc;
        q.push_back(e);
        chk("accept_after_release", int'(in_ready), 0);
        in_valid = 1'b0;
        scramble();

        // reset in the middle of a divide; last completed result was 11
        send(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
             mk_s(127, 127, 127, 127, 127, 127, 127, 127, 127), 0, 0, 0, t_acc);
        while (cyc < t_acc + 19) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_y", int'(y), 0);
        chk("midrst_den_zero", int'(den_zero), 0);

        send(16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000,
             mk_s(0, 0, 0, 0, 40, 0, 0, 0, 0), 40, 0, 1, t_acc);
        send(16'hFFFF, 16'h0000, 16'h0000, 16'h0001, 16'h0001, 16'h0000,
             mk_s(-7, 0, 0, 0, 0, 0, 0, 0, 0), -3, 0, 1, t_acc);

        n = 0;
        while (q.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", q.size(), 0);
        repeat (50) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
